// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the MEMS config UART link (receiver and transmitter).
//  - rx FSM state encoding
//  - default bit timing, inter-byte gap limit and link parity sense
//  - 16-bit config word payload (first byte on the wire in hi)
package uart_cfg_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 5208;  // 50 MHz / 9600 baud
  localparam int unsigned GAP_BITS_DEF     = 20;
  localparam bit          LINK_PARITY_ODD  = 1'b0;  // even parity on the link
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned WORD_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP,
    ST_BREAK
  } rx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } cfg_word_t;

endpackage

// File: rtl/uart_cfg_rx_if.sv
// Config-word output bus of the UART receiver.
//  master: the receiver, drives word and status pulses
//  slave : the config register file / observer
//  data       : last good config word
//  data_valid : 1-cycle pulse, data updated in the same cycle
//  parity_err, frame_err, gap_err : 1-cycle error pulses
//  busy       : receiver is inside a frame or holding a pending first byte
interface uart_cfg_rx_if;
  import uart_cfg_pkg::*;

  cfg_word_t data;
  logic      data_valid;
  logic      parity_err;
  logic      frame_err;
  logic      gap_err;
  logic      busy;

  modport master (output data, data_valid, parity_err, frame_err, gap_err, busy);
  modport slave  (input  data, data_valid, parity_err, frame_err, gap_err, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// Single 8E1 byte receiver: rx synchroniser, bit timing and START..STOP/BREAK.
//  sclk, rst_n  : clock, async active-low reset
//  rx           : raw serial line (idle high)
//  rx_byte      : last assembled byte (valid when byte_ok_c pulses)
//  byte_ok_c    : stop-bit centre high and parity good
//  par_bad_c    : stop-bit centre high but parity wrong
//  stop_bad_c   : stop-bit centre low (framing error)
//  active_nxt_c : next state is not IDLE
module uart_rx_byte
  import uart_cfg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit          PARITY_ODD   = LINK_PARITY_ODD
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_ok_c,
  output logic              par_bad_c,
  output logic              stop_bad_c,
  output logic              active_nxt_c
);

  localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] sh_q, sh_d;
  logic              par_acc_q, par_acc_d;
  logic              par_bad_q, par_bad_d;
  logic              rx_meta, rx_s, rx_s_d;
  logic              fall, mid, last;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;
  assign mid  = (cnt_q == MID);
  assign last = (cnt_q == LAST);

  // State register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      par_acc_q <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      par_acc_q <= par_acc_d;
      par_bad_q <= par_bad_d;
    end
  end

  // Next state: samples at bit centre, bit-to-bit transitions at bit end,
  // except STOP which leaves at its centre so a back-to-back start is caught.
  always_comb begin
    state_d      = state_q;
    cnt_d        = last ? '0 : cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    sh_d         = sh_q;
    par_acc_d    = par_acc_q;
    par_bad_d    = par_bad_q;
    byte_ok_c    = 1'b0;
    par_bad_c    = 1'b0;
    stop_bad_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (mid && rx_s) begin
          state_d = ST_IDLE;  // glitch, silently ignored
          cnt_d   = '0;
        end else if (last) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          bit_d     = '0;
          par_acc_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (mid) begin
          sh_d      = {rx_s, sh_q[BYTE_W-1:1]};  // LSB first
          par_acc_d = par_acc_q ^ rx_s;
        end
        if (last) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (mid) par_bad_d = par_acc_q ^ rx_s ^ PARITY_ODD;
        if (last) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end
      end
      ST_STOP: begin
        if (mid) begin
          cnt_d = '0;
          if (!rx_s) begin
            stop_bad_c = 1'b1;  // framing error outranks parity
            state_d    = ST_BREAK;
          end else begin
            par_bad_c = par_bad_q;
            byte_ok_c = ~par_bad_q;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        // Line must be continuously high for one bit-time before re-arming.
        if (!rx_s) begin
          cnt_d = '0;
        end else if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    active_nxt_c = (state_d != ST_IDLE);
  end

  assign rx_byte = sh_q;

endmodule

// File: rtl/uart_cfg_rx.sv
// MEMS config UART receiver: two 8E1 bytes (first byte = MSB) -> one 16-bit word.
//  sclk, rst_n : clock, async active-low reset
//  rx          : serial line, idle high, asynchronous to sclk
//  cfg         : master side of uart_cfg_rx_if (word, valid/error pulses, busy)
module uart_cfg_rx
  import uart_cfg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit          PARITY_ODD   = LINK_PARITY_ODD,
  parameter int unsigned GAP_BITS     = GAP_BITS_DEF
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          rx,
  uart_cfg_rx_if.master cfg
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned      GAP_W    = $clog2(GAP_BITS + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_ok_c, par_bad_c, stop_bad_c, active_nxt_c;

  logic              idx_q, idx_d;  // 1 = first byte held, waiting for second
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gbit_q, gbit_d;
  logic [BYTE_W-1:0] data_hi_q, data_hi_d;
  cfg_word_t         data_q, data_d;
  logic              dv_q, dv_d;
  logic              pe_q, pe_d;
  logic              fe_q, fe_d;
  logic              ge_q, ge_d;
  logic              busy_q, busy_d;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PARITY_ODD   (PARITY_ODD)
  ) u_byte (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .byte_ok_c    (byte_ok_c),
    .par_bad_c    (par_bad_c),
    .stop_bad_c   (stop_bad_c),
    .active_nxt_c (active_nxt_c)
  );

  // Word assembly state and registered outputs.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 1'b0;
      cnt_q     <= '0;
      gbit_q    <= '0;
      data_hi_q <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ge_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      gbit_q    <= gbit_d;
      data_hi_q <= data_hi_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ge_q      <= ge_d;
      busy_q    <= busy_d;
    end
  end

  // Byte events update the word; the gap timer only runs while a first byte
  // is pending and the byte receiver is idle, otherwise it stays cleared.
  always_comb begin
    idx_d     = idx_q;
    cnt_d     = '0;
    gbit_d    = '0;
    data_hi_d = data_hi_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
    ge_d      = 1'b0;
    if (stop_bad_c) begin
      fe_d  = 1'b1;
      idx_d = 1'b0;
    end else if (par_bad_c) begin
      pe_d  = 1'b1;
      idx_d = 1'b0;
    end else if (byte_ok_c) begin
      if (!idx_q) begin
        data_hi_d = rx_byte;
        idx_d     = 1'b1;
      end else begin
        data_d = '{hi: data_hi_q, lo: rx_byte};
        dv_d   = 1'b1;
        idx_d  = 1'b0;
      end
    end else if (idx_q && !active_nxt_c) begin
      cnt_d  = cnt_q + CNT_W'(1);
      gbit_d = gbit_q;
      if (cnt_q == LAST) begin
        cnt_d = '0;
        if (gbit_q == GAP_LAST) begin
          ge_d   = 1'b1;
          idx_d  = 1'b0;
          gbit_d = '0;
        end else begin
          gbit_d = gbit_q + GAP_W'(1);
        end
      end
    end
    busy_d = active_nxt_c | idx_d;
  end

  assign cfg.data       = data_q;
  assign cfg.data_valid = dv_q;
  assign cfg.parity_err = pe_q;
  assign cfg.frame_err  = fe_q;
  assign cfg.gap_err    = ge_q;
  assign cfg.busy       = busy_q;

endmodule

// File: tb/tb_uart_cfg_rx.sv
// Scoreboard bench for uart_cfg_rx (16 clocks/bit, 4-bit gap limit).
module tb_uart_cfg_rx;
  import uart_cfg_pkg::*;

  localparam int unsigned CPB  = 16;
  localparam int unsigned GAPB = 4;

  typedef enum int {EV_VALID = 0, EV_PAR = 1, EV_FRAME = 2, EV_GAP = 3} ev_e;
  typedef struct {
    ev_e         kind;
    logic [15:0] data;
  } exp_t;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  uart_cfg_rx_if cfg ();

  uart_cfg_rx #(
    .CLKS_PER_BIT (CPB),
    .PARITY_ODD   (1'b0),
    .GAP_BITS     (GAPB)
  ) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .rx    (rx),
    .cfg   (cfg)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_e k, input logic [15:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic bits(input logic v, input int n);
    rx = v;
    repeat (n * CPB) @(negedge sclk);
  endtask

  task automatic frame(input logic [7:0] b, input logic p, input logic stop);
    bits(1'b0, 1);
    for (int i = 0; i < 8; i++) bits(b[i], 1);
    bits(p, 1);
    bits(stop, 1);
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge sclk) begin : mon
    int  n;
    ev_e k;
    exp_t e;
    if (rst_n) begin
      n = int'(cfg.data_valid) + int'(cfg.parity_err) + int'(cfg.frame_err) + int'(cfg.gap_err);
      if (n > 1) begin
        check("single_pulse", n, 1);
      end else if (n == 1) begin
        k = cfg.data_valid ? EV_VALID : cfg.parity_err ? EV_PAR : cfg.frame_err ? EV_FRAME : EV_GAP;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got kind %0d expected none", int'(k));
        end else begin
          e = sb.pop_front();
          check("pulse_kind", int'(k), int'(e.kind));
          check("pulse_data", int'(cfg.data), int'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge sclk);
    check("rst_data", int'(cfg.data), 0);
    check("rst_busy", int'(cfg.busy), 0);
    check("rst_pulses", int'({cfg.data_valid, cfg.parity_err, cfg.frame_err, cfg.gap_err}), 0);
    rst_n = 1'b1;
    bits(1'b1, 2);

    // 1: good pair with one idle bit between bytes
    expect_ev(EV_VALID, 16'hA55A);
    frame(8'hA5, 1'b0, 1'b1);
    bits(1'b1, 1);
    frame(8'h5A, 1'b0, 1'b1);
    bits(1'b1, 2);
    check("t1_data", int'(cfg.data), 16'hA55A);

    // 2: back-to-back bytes, busy held while first byte pending
    expect_ev(EV_VALID, 16'h1301);
    frame(8'h13, 1'b1, 1'b1);
    check("t2_busy_gap", int'(cfg.busy), 1);
    frame(8'h01, 1'b1, 1'b1);
    check("t2_busy_end", int'(cfg.busy), 0);
    check("t2_data", int'(cfg.data), 16'h1301);

    // 3: parity error drops word, then good pair
    expect_ev(EV_PAR, 16'h1301);
    frame(8'hA5, 1'b1, 1'b1);
    bits(1'b1, 2);
    check("t3_data_hold", int'(cfg.data), 16'h1301);
    check("t3_busy", int'(cfg.busy), 0);
    expect_ev(EV_VALID, 16'h1234);
    frame(8'h12, 1'b0, 1'b1);
    frame(8'h34, 1'b1, 1'b1);
    bits(1'b1, 2);

    // 4: framing error, break hold-off, then good pair
    expect_ev(EV_FRAME, 16'h1234);
    frame(8'h12, 1'b0, 1'b0);
    bits(1'b0, 3);
    check("t4_busy_break", int'(cfg.busy), 1);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge sclk);
    check("t4_busy_half", int'(cfg.busy), 1);
    bits(1'b1, 2);
    check("t4_busy_idle", int'(cfg.busy), 0);
    expect_ev(EV_VALID, 16'hBEEF);
    frame(8'hBE, 1'b0, 1'b1);
    frame(8'hEF, 1'b1, 1'b1);
    bits(1'b1, 2);

    // 5: gap timeout after first byte, next pair not merged with it
    expect_ev(EV_GAP, 16'hBEEF);
    frame(8'h12, 1'b0, 1'b1);
    bits(1'b1, 3);
    check("t5_gap_pending", sb.size(), 1);
    bits(1'b1, 3);
    check("t5_gap_fired", sb.size(), 0);
    check("t5_busy", int'(cfg.busy), 0);
    expect_ev(EV_VALID, 16'hCAFE);
    frame(8'hCA, 1'b0, 1'b1);
    frame(8'hFE, 1'b1, 1'b1);
    bits(1'b1, 2);
    check("t5_data", int'(cfg.data), 16'hCAFE);

    // 6: short glitch ignored; reset mid second byte; recovery
    rx = 1'b0;
    repeat (5) @(negedge sclk);
    bits(1'b1, 2);
    check("t6_glitch_busy", int'(cfg.busy), 0);
    frame(8'h0F, 1'b0, 1'b1);
    bits(1'b0, 1);
    bits(1'b1, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data", int'(cfg.data), 0);
    check("t6_rst_busy", int'(cfg.busy), 0);
    check("t6_rst_valid", int'(cfg.data_valid), 0);
    rx = 1'b1;
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    bits(1'b1, 2);
    expect_ev(EV_VALID, 16'h0F0F);
    frame(8'h0F, 1'b0, 1'b1);
    frame(8'h0F, 1'b0, 1'b1);
    bits(1'b1, 2);
    check("t6_data", int'(cfg.data), 16'h0F0F);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
